array_port_arbiter: RTL and testbench
=====================================

ARRAY_PORT_ARBITER -- requirements
Module: array_port_arbiter

Interface
REQ-001 Parameter: CNT_W, default 16, width of the per-source transfer counters.
REQ-002 clk  input  1  clock; all state changes on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 a_in  input  int_5 (5 x 32-bit signed)  array offered by requester A.
REQ-005 a_in_sync  input  1  requester A has valid data on a_in.
REQ-006 a_in_notify  output  1  block is ready to accept from A (registered).
REQ-007 b_in  input  int_5  array offered by requester B.
REQ-008 b_in_sync  input  1  requester B has valid data on b_in.
REQ-009 b_in_notify  output  1  block is ready to accept from B (registered).
REQ-010 m_out  output  int_5  array forwarded to the shared consumer.
REQ-011 m_out_src  output  1  source of m_out: 0 = A, 1 = B.
REQ-012 m_out_sync  input  1  consumer ready to take m_out.
REQ-013 m_out_notify  output  1  m_out valid, offered to consumer (registered).
REQ-014 cnt_a, cnt_b  output  CNT_W each  number of arrays accepted from A / B.

Function
REQ-015 A transfer on any port SHALL occur exactly in a cycle where that port's notify and sync are both high at the rising edge.
REQ-016 FSM states SHALL be POLL_A, POLL_B, SEND; at most one of a_in_notify, b_in_notify, m_out_notify high in any cycle.
REQ-017 POLL_A: a_in_notify=1; if a_in_sync, capture a_in into buffer, m_out_src<=0, cnt_a+=1, go SEND; else go POLL_B.
REQ-018 POLL_B: b_in_notify=1; if b_in_sync, capture b_in into buffer, m_out_src<=1, cnt_b+=1, go SEND; else go POLL_A.
REQ-019 SEND: m_out_notify=1, m_out = buffer held stable; if m_out_sync, go POLL_B when m_out_src=0, POLL_A when m_out_src=1; else remain in SEND.
REQ-020 Latency: captured array SHALL appear on m_out with m_out_notify=1 in the cycle immediately after the input transfer edge.
REQ-021 Fairness: after serving one source, the other source SHALL be polled first; neither source waits more than one completed output transfer plus one poll cycle when offering continuously.
REQ-022 In SEND, a_in_sync/b_in_sync SHALL be ignored; no input captured, counters unchanged.
REQ-023 All 5 elements SHALL be captured and forwarded unmodified, element order preserved (index 0..4).
REQ-024 cnt_a/cnt_b SHALL wrap modulo 2^CNT_W without affecting FSM behaviour.
REQ-025 m_out and m_out_src SHALL change only on input capture; they hold last value outside SEND.
REQ-026 Sync inputs asserted while the corresponding notify is low SHALL have no effect.

Reset
REQ-027 On rst high, asynchronously: state=POLL_A, a_in_notify=1, b_in_notify=0, m_out_notify=0, m_out='{default:0}, m_out_src=0, cnt_a=0, cnt_b=0.
REQ-028 Reset asserted mid-SEND SHALL discard the buffered array; no output transfer completes after reset.
REQ-029 First cycle after rst release SHALL behave as POLL_A.

Verification
REQ-030 Reset release, a_in_sync=1, a_in='{1,2,3,4,5}, m_out_sync=1 -> next cycle m_out='{1,2,3,4,5}, m_out_src=0, m_out_notify=1, cnt_a=1; following cycle b_in_notify=1.
REQ-031 a_in_sync and b_in_sync held high continuously, m_out_sync=1 -> m_out_src sequence 0,1,0,1...; cnt_a and cnt_b differ by at most 1.
REQ-032 Only b_in_sync=1, b_in='{-1,0,7,-2147483648,2147483647} -> POLL_A one cycle, capture in POLL_B; m_out equals b_in bitwise, m_out_src=1.
REQ-033 m_out_sync=0 for 10 cycles in SEND while a_in/b_in change with syncs high -> m_out stable, both in_notify low, counters unchanged; release m_out_sync -> single transfer.
REQ-034 Assert rst during SEND -> m_out_notify=0, m_out all zero, counters 0, a_in_notify=1 immediately (asynchronous).
REQ-035 CNT_W=2, 5 transfers from A -> cnt_a sequence 1,2,3,0,1; arbitration unaffected.

Source files
------------

// File: rtl/array_port_arbiter_if.sv
// Bundle of the two requester ports, the shared consumer port and the transfer
// counters of array_port_arbiter. The slave side is the arbiter itself.
interface array_port_arbiter_if #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
);
  logic signed [DATA_W-1:0] a_in [5];
  logic                     a_in_sync;
  logic                     a_in_notify;
  logic signed [DATA_W-1:0] b_in [5];
  logic                     b_in_sync;
  logic                     b_in_notify;
  logic signed [DATA_W-1:0] m_out [5];
  logic                     m_out_src;
  logic                     m_out_sync;
  logic                     m_out_notify;
  logic [CNT_W-1:0]         cnt_a;
  logic [CNT_W-1:0]         cnt_b;

  modport slave (
    input  a_in, a_in_sync, b_in, b_in_sync, m_out_sync,
    output a_in_notify, b_in_notify, m_out, m_out_src, m_out_notify, cnt_a, cnt_b
  );

  modport master (
    output a_in, a_in_sync, b_in, b_in_sync, m_out_sync,
    input  a_in_notify, b_in_notify, m_out, m_out_src, m_out_notify, cnt_a, cnt_b
  );
endinterface

// File: rtl/array_port_arbiter.sv
// Two-requester round-robin arbiter forwarding 5-element signed arrays to one
// consumer through a single-entry buffer; requesters are polled alternately.
module array_port_arbiter #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  array_port_arbiter_if.slave  bus
);

  // One-hot encoding so each notify output is a direct flop bit.
  typedef enum logic [2:0] {
    POLL_A = 3'b001,
    POLL_B = 3'b010,
    SEND   = 3'b100
  } state_e;

  state_e                   state_q, state_d;
  logic signed [DATA_W-1:0] buf_q [5];
  logic signed [DATA_W-1:0] buf_d [5];
  logic                     src_q, src_d;
  logic [CNT_W-1:0]         cnt_a_q, cnt_a_d;
  logic [CNT_W-1:0]         cnt_b_q, cnt_b_d;

  always_comb begin
    state_d = state_q;
    buf_d   = buf_q;
    src_d   = src_q;
    cnt_a_d = cnt_a_q;
    cnt_b_d = cnt_b_q;
    unique case (state_q)
      POLL_A: begin
        if (bus.a_in_sync) begin
          buf_d   = bus.a_in;
          src_d   = 1'b0;
          cnt_a_d = cnt_a_q + 1'b1;
          state_d = SEND;
        end else begin
          state_d = POLL_B;
        end
      end
      POLL_B: begin
        if (bus.b_in_sync) begin
          buf_d   = bus.b_in;
          src_d   = 1'b1;
          cnt_b_d = cnt_b_q + 1'b1;
          state_d = SEND;
        end else begin
          state_d = POLL_A;
        end
      end
      SEND: begin
        // After delivering, poll the source that was not just served.
        if (bus.m_out_sync) begin
          state_d = src_q ? POLL_A : POLL_B;
        end
      end
      default: state_d = POLL_A;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= POLL_A;
      buf_q   <= '{default: '0};
      src_q   <= 1'b0;
      cnt_a_q <= '0;
      cnt_b_q <= '0;
    end else begin
      state_q <= state_d;
      buf_q   <= buf_d;
      src_q   <= src_d;
      cnt_a_q <= cnt_a_d;
      cnt_b_q <= cnt_b_d;
    end
  end

  assign bus.a_in_notify  = state_q[0];
  assign bus.b_in_notify  = state_q[1];
  assign bus.m_out_notify = state_q[2];
  assign bus.m_out        = buf_q;
  assign bus.m_out_src    = src_q;
  assign bus.cnt_a        = cnt_a_q;
  assign bus.cnt_b        = cnt_b_q;

endmodule

// File: tb/tb_array_port_arbiter.sv
// Scoreboard bench for array_port_arbiter: captures predicted from the polling
// rules are queued and popped when the consumer takes m_out.
module tb_array_port_arbiter;
  localparam int CW   = 2;
  localparam int MASK = (1 << CW) - 1;

  typedef struct packed {
    logic [159:0] d;
    logic         src;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  array_port_arbiter_if #(.DATA_W(32), .CNT_W(CW)) bus ();
  array_port_arbiter #(.DATA_W(32), .CNT_W(CW)) dut (.clk(clk), .rst(rst), .bus(bus));

  int   n_tot = 0;
  int   n_bad = 0;
  int   ms;          // 0 = POLL_A, 1 = POLL_B, 2 = SEND
  int   ea, eb;
  exp_t q[$];
  exp_t last;

  task automatic chk(input string tag, input logic [159:0] got, input logic [159:0] exp);
    n_tot++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [159:0] pack_a();
    logic [159:0] p;
    for (int i = 0; i < 5; i++) p[i*32 +: 32] = bus.a_in[i];
    return p;
  endfunction

  function automatic logic [159:0] pack_b();
    logic [159:0] p;
    for (int i = 0; i < 5; i++) p[i*32 +: 32] = bus.b_in[i];
    return p;
  endfunction

  function automatic logic [159:0] pack_out();
    logic [159:0] p;
    for (int i = 0; i < 5; i++) p[i*32 +: 32] = bus.m_out[i];
    return p;
  endfunction

  task automatic model_reset();
    ms = 0;
    ea = 0;
    eb = 0;
    q.delete();
    last = '0;
  endtask

  task automatic check_ctrl();
    chk("a_notify", bus.a_in_notify, ms == 0);
    chk("b_notify", bus.b_in_notify, ms == 1);
    chk("m_notify", bus.m_out_notify, ms == 2);
    chk("cnt_a", bus.cnt_a, ea);
    chk("cnt_b", bus.cnt_b, eb);
  endtask

  task automatic rnd_in();
    for (int i = 0; i < 5; i++) begin
      bus.a_in[i] = $urandom;
      bus.b_in[i] = $urandom;
    end
  endtask

  // Drive syncs, predict the coming edge, then check control after it.
  task automatic step(input bit as, input bit bs, input bit mo);
    exp_t e;
    bus.a_in_sync  = as;
    bus.b_in_sync  = bs;
    bus.m_out_sync = mo;
    if (ms != 2) begin
      chk("m_out_hold", pack_out(), last.d);
      chk("src_hold", bus.m_out_src, last.src);
    end
    case (ms)
      0: begin
        if (as) begin
          e.d = pack_a(); e.src = 1'b0; q.push_back(e);
          ea = (ea + 1) & MASK; ms = 2;
        end else ms = 1;
      end
      1: begin
        if (bs) begin
          e.d = pack_b(); e.src = 1'b1; q.push_back(e);
          eb = (eb + 1) & MASK; ms = 2;
        end else ms = 0;
      end
      default: begin
        chk("sb_nonempty", q.size() != 0, 1);
        if (q.size() != 0) begin
          chk("m_out", pack_out(), q[0].d);
          chk("m_src", bus.m_out_src, q[0].src);
          if (mo) begin
            last = q.pop_front();
            ms = last.src ? 0 : 1;
          end
        end else ms = 0;
      end
    endcase
    @(posedge clk);
    #1;
    check_ctrl();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    bus.a_in_sync = 1'b0; bus.b_in_sync = 1'b0; bus.m_out_sync = 1'b0;
    for (int i = 0; i < 5; i++) begin bus.a_in[i] = '0; bus.b_in[i] = '0; end
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_ctrl();
    chk("rst_m_out", pack_out(), '0);
    chk("rst_src", bus.m_out_src, 1'b0);
    rst = 1'b0;

    // First transfer from A right after reset release.
    for (int i = 0; i < 5; i++) bus.a_in[i] = i + 1;
    step(1, 0, 1);
    step(0, 0, 1);
    step(0, 0, 0);

    // Both requesters offering continuously: alternation A/B.
    for (int k = 0; k < 12; k++) begin rnd_in(); step(1, 1, 1); end

    // Only B offers, with extreme values.
    bus.b_in[0] = -1; bus.b_in[1] = 0; bus.b_in[2] = 7;
    bus.b_in[3] = 32'sh8000_0000; bus.b_in[4] = 32'sh7fff_ffff;
    for (int k = 0; k < 6; k++) step(0, 1, 1);

    // Consumer back-pressure for 10 cycles while inputs keep changing.
    for (int k = 0; k < 3 && ms != 2; k++) step(1, 1, 1);
    for (int k = 0; k < 10; k++) begin rnd_in(); step(1, 1, 0); end
    step(1, 1, 1);
    for (int k = 0; k < 4; k++) step(0, 0, 1);

    // Random traffic.
    for (int k = 0; k < 200; k++) begin
      rnd_in();
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 2) != 0));
    end

    // Asynchronous reset while holding a buffered array.
    for (int k = 0; k < 4 && ms != 2; k++) begin rnd_in(); step(1, 1, 0); end
    chk("in_send", ms, 2);
    #3;
    rst = 1'b1;
    #1;
    model_reset();
    check_ctrl();
    chk("arst_m_out", pack_out(), '0);
    chk("arst_src", bus.m_out_src, 1'b0);
    bus.a_in_sync = 1'b1; bus.b_in_sync = 1'b1; bus.m_out_sync = 1'b1;
    @(posedge clk);
    #1;
    check_ctrl();
    rst = 1'b0;

    // Five transfers from A only: counter wraps at 2 bits.
    for (int k = 0; k < 5; k++) begin
      rnd_in();
      step(1, 0, 1);
      step(1, 0, 1);
      step(1, 0, 1);
    end
    step(0, 0, 1);

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end
endmodule
